// File: rtl/packet_dispatcher_pkg.sv
// Shared classifier pipeline definitions: header width defaults, counter widths
// and the dispatch state encoding used by the packet dispatcher.
package packet_dispatcher_pkg;

  localparam int CLS_PACKET_WIDTH = 104;
  localparam int CLS_COUNT_WIDTH  = 32;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_PAIR = 1'b1
  } disp_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/packet_dispatcher_fifo.sv
// Circular header buffer: single push per edge, pop of 0/1/2 entries per edge,
// exposes the two oldest entries so a pair can leave in one cycle.
module dispatch_fifo
  import packet_dispatcher_pkg::*;
#(
  parameter int WIDTH = CLS_PACKET_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic [1:0]               pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [WIDTH-1:0]         head_next_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;

  // Payload storage carries no reset; emptiness is defined by the pointers and level.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push_i);
      rd_ptr_q <= rd_ptr_q + AW'(pop_i);
      level_q  <= level_q + LW'(push_i) - LW'(pop_i);
    end
  end

  assign head_o      = mem_q[rd_ptr_q];
  assign head_next_o = mem_q[rd_ptr_q + AW'(1)];
  assign level_o     = level_q;

endmodule

// File: rtl/packet_dispatcher.sv
// Two-lane header dispatcher: buffers ingress headers and releases them in
// pairs, or alone after a bounded wait for a partner or on flush.
module packet_dispatcher
  import packet_dispatcher_pkg::*;
#(
  parameter int PACKET_WIDTH = CLS_PACKET_WIDTH,
  parameter int FIFO_DEPTH   = 8,
  parameter int HOLD_CYCLES  = 4
) (
  input  logic                          clk,
  input  logic                          RSTn,
  input  logic [PACKET_WIDTH-1:0]       s_packet,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          stall,
  input  logic                          flush,
  output logic [PACKET_WIDTH-1:0]       packet_out1,
  output logic [PACKET_WIDTH-1:0]       packet_out2,
  output logic                          data_valid_out1,
  output logic                          data_valid_out2,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CLS_COUNT_WIDTH-1:0]    pkt_count
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = cnt_width(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  logic                       push_s;
  logic [1:0]                 pop_s;
  logic [LW-1:0]              level_s;
  logic [LW-1:0]              level_nxt_s;
  logic [PACKET_WIDTH-1:0]    head_s;
  logic [PACKET_WIDTH-1:0]    head_next_s;

  disp_state_e                state_q;
  logic [CW-1:0]              wait_cnt_q;
  logic                       s_ready_q;
  logic [CLS_COUNT_WIDTH-1:0] pkt_count_q;
  logic [PACKET_WIDTH-1:0]    packet_out1_q;
  logic [PACKET_WIDTH-1:0]    packet_out2_q;
  logic                       dv1_q;
  logic                       dv2_q;

  assign push_s      = s_valid & s_ready_q;
  assign level_nxt_s = level_s + LW'(push_s) - LW'(pop_s);

  // Pop decision uses only registered level/state so a same-edge push never pairs early.
  always_comb begin
    pop_s = 2'd0;
    if (stall) begin
      pop_s = 2'd0;
    end else if (level_s >= LW'(2)) begin
      pop_s = 2'd2;
    end else if ((level_s == LW'(1)) &&
                 (flush || ((state_q == WAIT_PAIR) && (wait_cnt_q == HOLD_LAST)))) begin
      pop_s = 2'd1;
    end else begin
      pop_s = 2'd0;
    end
  end

  dispatch_fifo #(
    .WIDTH (PACKET_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (RSTn),
    .push_i      (push_s),
    .push_data_i (s_packet),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .head_next_o (head_next_s),
    .level_o     (level_s)
  );

  // Dispatch FSM with registered lane outputs, ingress ready and dispatch counter.
  always_ff @(posedge clk or posedge RSTn) begin
    if (RSTn) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      s_ready_q     <= 1'b0;
      pkt_count_q   <= '0;
      packet_out1_q <= '0;
      packet_out2_q <= '0;
      dv1_q         <= 1'b0;
      dv2_q         <= 1'b0;
    end else begin
      s_ready_q   <= (level_nxt_s < LW'(FIFO_DEPTH));
      pkt_count_q <= pkt_count_q + CLS_COUNT_WIDTH'(pop_s);
      dv1_q       <= 1'b0;
      dv2_q       <= 1'b0;
      if (stall) begin
        state_q    <= state_q;
        wait_cnt_q <= wait_cnt_q;
      end else if (pop_s != 2'd0) begin
        dv1_q         <= 1'b1;
        dv2_q         <= (pop_s == 2'd2);
        packet_out1_q <= head_s;
        if (pop_s == 2'd2) begin
          packet_out2_q <= head_next_s;
        end
        state_q    <= IDLE;
        wait_cnt_q <= '0;
      end else if (level_s == LW'(1)) begin
        if (state_q == IDLE) begin
          state_q    <= WAIT_PAIR;
          wait_cnt_q <= '0;
        end else begin
          wait_cnt_q <= wait_cnt_q + CW'(1);
        end
      end else begin
        state_q    <= IDLE;
        wait_cnt_q <= '0;
      end
    end
  end

  assign s_ready         = s_ready_q;
  assign packet_out1     = packet_out1_q;
  assign packet_out2     = packet_out2_q;
  assign data_valid_out1 = dv1_q;
  assign data_valid_out2 = dv2_q;
  assign fifo_level      = level_s;
  assign pkt_count       = pkt_count_q;

endmodule
